decode_exec_queue: RTL and testbench
====================================

Name: decode_exec_queue

Overview:
Parametrised successor to the single-slot decode-to-execute bus. It is a DEPTH-entry FIFO of DecodeExecPacket between the decode and execute stages, with valid/ready handshakes on both sides. It also provides operand-count masking, occupancy and almost-full reporting, and a pipeline flush for branch redirects. Decode pushes one packet per cycle; execute pops one per cycle.

Parameters:
DEPTH, 4, number of packet entries; power of two, >= 2
AFULL_THRESH, DEPTH-1, occupancy at or above which almost_full asserts; range 1..DEPTH
MAX_OPERANDS, 3, number of vector operand slots carried (value0..value2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
send_valid  in  1  decode presents a packet
send_ready  out  1  queue can accept; = !full
send_num_operands  in  2  operands valid in send_packet, 1..MAX_OPERANDS
send_packet  in  $bits(DecodeExecPacket)  exec_mask, PC, opcode, value0..value2
recv_valid  out  1  head entry valid; = !empty
recv_ready  in  1  execute consumes head
recv_packet  out  $bits(DecodeExecPacket)  head entry, combinational from storage
flush  in  1  discard all entries (branch redirect)
count  out  $clog2(DEPTH+1)  current occupancy
almost_full  out  1  count >= AFULL_THRESH
bad_operands  out  1  sticky error: a push was attempted with num_operands 0 or > MAX_OPERANDS

Behaviour:
- Reset (async assert, sync release): rd_ptr=wr_ptr=0, count=0, send_ready=1, recv_valid=0, almost_full=0, bad_operands=0. recv_packet is don't-care while recv_valid=0. Reset mid-operation discards all entries.
- push = send_valid & send_ready & !flush; pop = recv_valid & recv_ready & !flush.
- On push:
  - Write the entry at wr_ptr.
  - Value slots with index >= send_num_operands are stored as zero. This replaces the stale-field behaviour of send_req1/2.
  - wr_ptr wraps modulo DEPTH.
- On pop: rd_ptr advances modulo DEPTH.
- Latency: a pushed packet is visible on recv_packet/recv_valid the cycle after acceptance. There is no same-cycle bypass.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count==DEPTH): send_ready=0 and the push is not accepted. A pop in that cycle frees the slot only for the next cycle; there is no write-through.
- Empty (count==0): recv_valid=0 and recv_ready is ignored.
- Count: +1 on push only, -1 on pop only. It never exceeds DEPTH and never underflows.
- flush:
  - Takes effect at the next edge: pointers=0, count=0.
  - Overrides any push or pop in the same cycle; both are dropped.
  - send_ready stays 1 during flush. Decode must treat a flush-cycle send as not accepted.
- bad_operands:
  - Set on any send_valid & send_ready cycle with send_num_operands==0 or > MAX_OPERANDS.
  - The packet is still accepted, with all value slots stored as zero.
  - Cleared only by reset.
- Producer rule: once send_valid rises, send_packet must hold until accepted. A simulation assertion fires on violation.
- Consumer rule: recv_packet stays stable while recv_valid & !recv_ready.
- Simulation assertions: no push when full, no pop when empty (internal consistency checks).
- State: pointer/count registers only. There is no FSM beyond the empty/partial/full occupancy states.

Decomposition:
- Shared package cpu_types holds:
  - DecodeExecPacket, ExecuteStageOpcode, execution_mask_t, memory_address_t, DecodeStageValue, VectorValue
  - constant MAX_VECTOR_OPERANDS=3
- One natural sub-module: decode_exec_fifo_mem.
  - DEPTH x DecodeExecPacket register array.
  - Write port: we, waddr, wdata. Asynchronous read port: raddr, rdata.
  - No reset on storage.
- The pointer/count/flag logic stays in decode_exec_queue.

Test Plan:
1. Reset, then push one packet (PC=0x100, num_operands=1, value1/value2 driven nonzero) -> recv_valid=1 next cycle, recv_packet.PC=0x100, value1=value2=0, count=1.
2. DEPTH=4, push 4 with recv_ready=0 -> send_ready=0 and count=4 after the 4th. A 5th send is not accepted. Pop 4 -> PCs emerge in push order, recv_valid=0 after the last.
3. Steady stream with send_valid=recv_ready=1 and count=2 -> count stays 2 for 20 cycles, pointers wrap past DEPTH, no packet lost or duplicated.
4. With count=3, assert flush together with send_valid and recv_ready -> next cycle count=0, recv_valid=0, and neither the flushed nor the concurrently sent packet appears.
5. Push with num_operands=0 -> packet accepted, value0..value2=0, bad_operands=1 and stays 1 until reset.
6. Assert reset asynchronously mid-stream with count=2 -> count=0, recv_valid=0, send_ready=1 immediately, before the next clk edge. almost_full=1 only while count>=AFULL_THRESH (3 for DEPTH=4).

Source files
------------

// File: rtl/cpu_types.sv
// Shared decode/execute types: packet layout, opcode set and operand-masking helpers.
package cpu_types;

    localparam int unsigned MAX_VECTOR_OPERANDS = 3;
    localparam int unsigned OPERAND_IDX_W       = $clog2(MAX_VECTOR_OPERANDS);
    localparam int unsigned VECTOR_VALUE_W      = 32;

    typedef logic [3:0]                    execution_mask_t;
    typedef logic [31:0]                   memory_address_t;
    typedef logic [VECTOR_VALUE_W-1:0]     VectorValue;
    typedef VectorValue [MAX_VECTOR_OPERANDS-1:0] DecodeStageValue;

    typedef enum logic [3:0] {
        EXEC_NOP    = 4'd0,
        EXEC_ADD    = 4'd1,
        EXEC_SUB    = 4'd2,
        EXEC_MUL    = 4'd3,
        EXEC_AND    = 4'd4,
        EXEC_OR     = 4'd5,
        EXEC_XOR    = 4'd6,
        EXEC_LOAD   = 4'd7,
        EXEC_STORE  = 4'd8,
        EXEC_BRANCH = 4'd9
    } ExecuteStageOpcode;

    typedef struct packed {
        execution_mask_t   exec_mask;
        memory_address_t   pc;
        ExecuteStageOpcode opcode;
        DecodeStageValue   value;
    } DecodeExecPacket;

    function automatic logic operand_count_bad(input logic [1:0] num, input int unsigned max_ops);
        return (num == 2'd0) || ({30'd0, num} > max_ops);
    endfunction

    // Slots at or beyond the operand count are zeroed; a bad count zeroes every slot.
    function automatic DecodeStageValue mask_operands(input DecodeStageValue v,
                                                      input logic [1:0]      num,
                                                      input logic            bad);
        DecodeStageValue m;
        m = v;
        for (int unsigned i = 0; i < MAX_VECTOR_OPERANDS; i++) begin
            if (bad || (i >= {30'd0, num})) begin
                m[i[OPERAND_IDX_W-1:0]] = '0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/decode_exec_fifo_mem.sv
// Packet storage for the decode/execute queue: synchronous write, asynchronous read, no reset.
module decode_exec_fifo_mem
    import cpu_types::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  DecodeExecPacket          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output DecodeExecPacket          rdata
);

    DecodeExecPacket mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/decode_exec_queue.sv
// DEPTH-entry decode-to-execute packet FIFO with operand masking, occupancy flags and flush.
module decode_exec_queue
    import cpu_types::*;
#(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned AFULL_THRESH = DEPTH - 1,
    parameter int unsigned MAX_OPERANDS = MAX_VECTOR_OPERANDS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       send_valid,
    output logic                       send_ready,
    input  logic [1:0]                 send_num_operands,
    input  DecodeExecPacket            send_packet,
    output logic                       recv_valid,
    input  logic                       recv_ready,
    output DecodeExecPacket            recv_packet,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       bad_operands
);

    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            push;
    logic            pop;
    logic            num_bad;
    DecodeExecPacket wr_packet;

    // Flags derive from the count register so an async reset shows on them immediately.
    assign send_ready  = (count != DEPTH_C);
    assign recv_valid  = (count != '0);
    assign almost_full = (count >= AFULL_C);

    assign push    = send_valid && send_ready && !flush;
    assign pop     = recv_valid && recv_ready && !flush;
    assign num_bad = operand_count_bad(send_num_operands, MAX_OPERANDS);

    always_comb begin
        wr_packet       = send_packet;
        wr_packet.value = mask_operands(send_packet.value, send_num_operands, num_bad);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            bad_operands <= 1'b0;
        end else begin
            // The error flag samples the handshake itself, so a flush-cycle send still sets it.
            if (send_valid && send_ready && num_bad) begin
                bad_operands <= 1'b1;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                unique case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    decode_exec_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_packet),
        .raddr (rd_ptr),
        .rdata (recv_packet)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        push |-> (count != DEPTH_C));

    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
        pop |-> (count != '0));

    a_producer_hold: assert property (@(posedge clk) disable iff (reset)
        (send_valid && !send_ready && !flush) |=> $stable(send_packet));

    a_consumer_stable: assert property (@(posedge clk) disable iff (reset)
        (recv_valid && !recv_ready && !flush) |=> $stable(recv_packet));

endmodule

// File: tb/tb_decode_exec_queue.sv
// Randomised scoreboard bench for decode_exec_queue with directed corner sequences.
module tb_decode_exec_queue;
    import cpu_types::*;

    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic            clk;
    logic            reset;
    logic            send_valid;
    logic            send_ready;
    logic [1:0]      send_num_operands;
    DecodeExecPacket send_packet;
    logic            recv_valid;
    logic            recv_ready;
    DecodeExecPacket recv_packet;
    logic            flush;
    logic [2:0]      count;
    logic            almost_full;
    logic            bad_operands;

    int total = 0;
    int bad   = 0;

    int              occ       = 0;
    int              occ_next  = 0;
    logic            bad_model = 1'b0;
    logic            bad_next  = 1'b0;
    logic            mon_en    = 1'b0;
    logic            blocked   = 1'b0;
    DecodeExecPacket held_pkt;
    logic [1:0]      held_n;
    DecodeExecPacket exp_q[$];
    logic [31:0]     pc_seq = 32'h200;

    decode_exec_queue #(
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL),
        .MAX_OPERANDS (3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .send_valid        (send_valid),
        .send_ready        (send_ready),
        .send_num_operands (send_num_operands),
        .send_packet       (send_packet),
        .recv_valid        (recv_valid),
        .recv_ready        (recv_ready),
        .recv_packet       (recv_packet),
        .flush             (flush),
        .count             (count),
        .almost_full       (almost_full),
        .bad_operands      (bad_operands)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic DecodeExecPacket rand_pkt(input logic [31:0] pc);
        DecodeExecPacket p;
        p.exec_mask = 4'($urandom);
        p.pc        = pc;
        p.opcode    = ExecuteStageOpcode'(4'($urandom_range(0, 9)));
        p.value[0]  = $urandom | 32'h1;
        p.value[1]  = $urandom | 32'h1;
        p.value[2]  = $urandom | 32'h1;
        return p;
    endfunction

    // Reference: n valid operands keep value0..value(n-1); 0 operands keeps none.
    function automatic DecodeExecPacket expect_pkt(input DecodeExecPacket p, input logic [1:0] n);
        DecodeExecPacket e;
        e = p;
        if (n < 2'd1) e.value[0] = '0;
        if (n < 2'd2) e.value[1] = '0;
        if (n < 2'd3) e.value[2] = '0;
        return e;
    endfunction

    // Drives one cycle at posedge+1, predicts its outcome, and returns at the next posedge+1.
    task automatic step(input logic sv, input logic [1:0] n, input DecodeExecPacket p,
                        input logic rr, input logic fl);
        logic accept;
        logic popped;
        send_valid = sv;
        if (sv) begin
            send_packet       = p;
            send_num_operands = n;
        end
        recv_ready = rr;
        flush      = fl;
        accept  = sv && (occ < DEPTH) && !fl;
        popped  = rr && (occ > 0) && !fl;
        blocked = sv && (occ >= DEPTH) && !fl;
        held_pkt = p;
        held_n   = n;
        if (sv && (occ < DEPTH) && (n == 2'd0)) bad_next = 1'b1;
        if (fl) begin
            exp_q.delete();
            occ_next = 0;
        end else begin
            if (accept) exp_q.push_back(expect_pkt(p, n));
            occ_next = occ + (accept ? 1 : 0) - (popped ? 1 : 0);
        end
        @(posedge clk);
        #1;
        occ       = occ_next;
        bad_model = bad_next;
    endtask

    task automatic push_new(input logic [1:0] n, input logic rr);
        step(1'b1, n, rand_pkt(pc_seq), rr, 1'b0);
        pc_seq += 32'h4;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && occ != 0; i++) step(1'b0, 2'd1, held_pkt, 1'b1, 1'b0);
    endtask

    // Monitor: flag checks every cycle, scoreboard pop on every real dequeue.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("count", count, occ);
                check("recv_valid", recv_valid, occ != 0);
                check("send_ready", send_ready, occ != DEPTH);
                check("almost_full", almost_full, occ >= AFULL);
                check("bad_operands", bad_operands, bad_model);
                if (recv_valid && recv_ready && !flush && !reset) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_extra: got packet %0h want none", recv_packet);
                    end else begin
                        check("packet", recv_packet, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        DecodeExecPacket p;
        reset             = 1'b1;
        send_valid        = 1'b0;
        recv_ready        = 1'b0;
        flush             = 1'b0;
        send_num_operands = 2'd1;
        send_packet       = '0;
        held_pkt          = '0;
        held_n            = 2'd1;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        check("rst_count", count, 0);
        check("rst_send_ready", send_ready, 1);
        check("rst_recv_valid", recv_valid, 0);
        check("rst_almost_full", almost_full, 0);
        check("rst_bad_operands", bad_operands, 0);

        // One operand: only value0 survives, visible the cycle after acceptance.
        p = rand_pkt(32'h100);
        step(1'b1, 2'd1, p, 1'b0, 1'b0);
        check("t1_recv_valid", recv_valid, 1);
        check("t1_pc", recv_packet.pc, 32'h100);
        check("t1_value1", recv_packet.value[1], 0);
        check("t1_value2", recv_packet.value[2], 0);
        step(1'b0, 2'd1, p, 1'b1, 1'b0);

        // Fill to full, rejected fifth send, then drain in order.
        for (int i = 0; i < DEPTH; i++) push_new(2'd3, 1'b0);
        check("t2_send_ready_full", send_ready, 0);
        push_new(2'd2, 1'b0);
        check("t2_count_after_5th", count, 4);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 2'd1, held_pkt, 1'b1, 1'b0);
        check("t2_recv_valid_empty", recv_valid, 0);

        // Steady stream at occupancy two; pointers wrap several times.
        push_new(2'd2, 1'b0);
        push_new(2'd1, 1'b0);
        for (int i = 0; i < 20; i++) push_new(2'($urandom_range(1, 3)), 1'b1);
        check("t3_count_steady", count, 2);
        drain();

        // Flush at occupancy three with a concurrent send and pop: everything dropped.
        for (int i = 0; i < 3; i++) push_new(2'd3, 1'b0);
        step(1'b1, 2'd3, rand_pkt(32'hDEAD0), 1'b1, 1'b1);
        check("t4_count_flushed", count, 0);
        check("t4_recv_valid", recv_valid, 0);
        step(1'b0, 2'd1, held_pkt, 1'b1, 1'b0);
        push_new(2'd2, 1'b0);
        step(1'b0, 2'd1, held_pkt, 1'b1, 1'b0);

        // Zero operands: accepted with all values zeroed, error flag sticks.
        push_new(2'd0, 1'b0);
        check("t5_bad_operands", bad_operands, 1);
        step(1'b0, 2'd1, held_pkt, 1'b1, 1'b0);
        repeat (3) step(1'b0, 2'd1, held_pkt, 1'b0, 1'b0);

        // Random traffic with occasional flushes; blocked sends are held.
        for (int c = 0; c < 200; c++) begin
            logic       sv;
            logic       rr;
            logic       fl;
            logic [1:0] n;
            fl = ($urandom_range(0, 24) == 0);
            rr = ($urandom_range(0, 2) != 0);
            if (blocked) begin
                sv = 1'b1;
                p  = held_pkt;
                n  = held_n;
            end else begin
                sv = ($urandom_range(0, 3) != 0);
                n  = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
                p  = rand_pkt(pc_seq);
                pc_seq += 32'h4;
            end
            step(sv, n, p, rr, fl);
        end
        drain();

        // Asynchronous reset mid-stream at occupancy two.
        push_new(2'd3, 1'b0);
        push_new(2'd3, 1'b0);
        push_new(2'd2, 1'b1);
        bad_next = 1'b1;
        bad_model = 1'b1;
        push_new(2'd0, 1'b1);
        #1;
        reset      = 1'b1;
        send_valid = 1'b0;
        recv_ready = 1'b0;
        flush      = 1'b0;
        exp_q.delete();
        occ       = 0;
        occ_next  = 0;
        bad_model = 1'b0;
        bad_next  = 1'b0;
        blocked   = 1'b0;
        #1;
        check("t6_count", count, 0);
        check("t6_recv_valid", recv_valid, 0);
        check("t6_send_ready", send_ready, 1);
        check("t6_almost_full", almost_full, 0);
        check("t6_bad_operands", bad_operands, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) push_new(2'($urandom_range(1, 3)), 1'b0);
        drain();
        repeat (2) step(1'b0, 2'd1, held_pkt, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
